// File: rtl/udp_rx_port_demux_filter_if.sv
// Channel bundles for the UDP RX port demux: metadata records, the raw
// payload stream coming from the RX stage, and the filtered AXI-stream output.

interface udp_rx_meta_if #(
  parameter int IP_ADDR_WIDTH  = 32,
  parameter int UDP_PORT_WIDTH = 16,
  parameter int UDP_LEN_WIDTH  = 16
);
  logic                      valid;
  logic                      ready;
  logic [IP_ADDR_WIDTH-1:0]  ip_addr;
  logic [UDP_PORT_WIDTH-1:0] dst_port;
  logic [UDP_PORT_WIDTH-1:0] src_port;
  logic [UDP_LEN_WIDTH-1:0]  data_len;

  modport master (output valid, ip_addr, dst_port, src_port, data_len, input ready);
  modport slave  (input valid, ip_addr, dst_port, src_port, data_len, output ready);
endinterface

interface udp_rx_stream_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tfirst;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tfirst, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tfirst, tlast, output tready);
endinterface

interface udp_rx_axis_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/udp_rx_port_demux_filter.sv
// Pairs UDP metadata with its payload, forwards packets for the listen port
// through a one-deep register slice and drains/counts everything else.

module udp_rx_port_demux_filter #(
  parameter int DATA_WIDTH     = 256,
  parameter int KEEP_WIDTH     = 32,
  parameter int UDP_LEN_WIDTH  = 16,
  parameter int IP_ADDR_WIDTH  = 32,
  parameter int UDP_PORT_WIDTH = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UDP_PORT_WIDTH-1:0] cfg_listen_port_i,
  input  logic                      cfg_filter_en_i,
  udp_rx_meta_if.slave              s_udp_meta,
  udp_rx_stream_if.slave            s_data_stream,
  udp_rx_axis_if.master             m_axis,
  output logic [IP_ADDR_WIDTH-1:0]  m_pkt_src_ip_o,
  output logic [UDP_PORT_WIDTH-1:0] m_pkt_src_port_o,
  output logic [UDP_LEN_WIDTH-1:0]  m_pkt_len_o,
  output logic [CNT_WIDTH-1:0]      stat_fwd_cnt_o,
  output logic [CNT_WIDTH-1:0]      stat_drop_cnt_o,
  output logic [CNT_WIDTH-1:0]      stat_len_err_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam int BCNT_W = UDP_LEN_WIDTH + 1;
  localparam int SUM_W  = BCNT_W + 1;
  localparam int POP_W  = $clog2(KEEP_WIDTH + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  logic [1:0]                state_q, state_d;
  logic [IP_ADDR_WIDTH-1:0]  pkt_src_ip_q;
  logic [UDP_PORT_WIDTH-1:0] pkt_src_port_q;
  logic [UDP_LEN_WIDTH-1:0]  pkt_len_q;
  logic [BCNT_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic                      beat_seen_q;
  logic                      tfirst_err_q;

  logic                      out_valid_q;
  logic [DATA_WIDTH-1:0]     out_data_q;
  logic [KEEP_WIDTH-1:0]     out_keep_q;
  logic                      out_last_q;
  logic                      out_user_q;

  logic [CNT_WIDTH-1:0]      fwd_cnt_q;
  logic [CNT_WIDTH-1:0]      drop_cnt_q;
  logic [CNT_WIDTH-1:0]      len_err_cnt_q;

  logic                      meta_ready;
  logic                      data_ready;
  logic                      meta_hs;
  logic                      data_hs;
  logic                      fwd_sel;
  logic [POP_W-1:0]          keep_pop;
  logic [SUM_W-1:0]          byte_sum;
  logic                      tfirst_bad;
  logic                      len_err;

  // Readies are held low while reset is asserted so nothing is consumed then.
  always_comb begin
    meta_ready = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      ST_IDLE: meta_ready = !reset;
      ST_FWD:  data_ready = !reset && (!out_valid_q || m_axis.tready);
      ST_DROP: data_ready = !reset;
      default: ;
    endcase
  end

  assign meta_hs = s_udp_meta.valid && meta_ready;
  assign data_hs = s_data_stream.tvalid && data_ready;
  assign fwd_sel = !cfg_filter_en_i || (s_udp_meta.dst_port == cfg_listen_port_i);

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_pop = keep_pop + POP_W'(s_data_stream.tkeep[i]);
    end
  end

  // Byte counter is one bit wider than the length field and sticks at full scale.
  assign byte_sum   = {1'b0, byte_cnt_q} + SUM_W'(keep_pop);
  assign byte_cnt_d = byte_sum[BCNT_W] ? BCNT_MAX : byte_sum[BCNT_W-1:0];

  assign tfirst_bad = s_data_stream.tfirst && beat_seen_q;
  assign len_err    = tfirst_err_q || tfirst_bad || (byte_cnt_d != {1'b0, pkt_len_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (meta_hs) state_d = fwd_sel ? ST_FWD : ST_DROP;
      ST_FWD,
      ST_DROP: if (data_hs && s_data_stream.tlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pkt_src_ip_q   <= '0;
      pkt_src_port_q <= '0;
      pkt_len_q      <= '0;
      byte_cnt_q     <= '0;
      beat_seen_q    <= 1'b0;
      tfirst_err_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_keep_q     <= '0;
      out_last_q     <= 1'b0;
      out_user_q     <= 1'b0;
      fwd_cnt_q      <= '0;
      drop_cnt_q     <= '0;
      len_err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      if (meta_hs) begin
        pkt_src_ip_q   <= s_udp_meta.ip_addr;
        pkt_src_port_q <= s_udp_meta.src_port;
        pkt_len_q      <= s_udp_meta.data_len;
        byte_cnt_q     <= '0;
        beat_seen_q    <= 1'b0;
        tfirst_err_q   <= 1'b0;
      end

      if (data_hs) begin
        byte_cnt_q   <= byte_cnt_d;
        beat_seen_q  <= 1'b1;
        tfirst_err_q <= tfirst_err_q | tfirst_bad;
      end

      // Output slice: load on a forwarded beat, otherwise drain when taken.
      if (data_hs && (state_q == ST_FWD)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= s_data_stream.tdata;
        out_keep_q  <= s_data_stream.tkeep;
        out_last_q  <= s_data_stream.tlast;
        out_user_q  <= s_data_stream.tlast && len_err;
      end else if (m_axis.tready) begin
        out_valid_q <= 1'b0;
      end

      if (data_hs && s_data_stream.tlast) begin
        if (state_q == ST_FWD) begin
          fwd_cnt_q <= fwd_cnt_q + CNT_WIDTH'(1);
        end else begin
          drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
        if (len_err) begin
          len_err_cnt_q <= len_err_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign s_udp_meta.ready     = meta_ready;
  assign s_data_stream.tready = data_ready;

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tkeep  = out_keep_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tuser  = out_user_q;

  assign m_pkt_src_ip_o     = pkt_src_ip_q;
  assign m_pkt_src_port_o   = pkt_src_port_q;
  assign m_pkt_len_o        = pkt_len_q;
  assign stat_fwd_cnt_o     = fwd_cnt_q;
  assign stat_drop_cnt_o    = drop_cnt_q;
  assign stat_len_err_cnt_o = len_err_cnt_q;

endmodule

// File: tb/tb_udp_rx_port_demux_filter.sv
// Randomised bench for the UDP RX port demux: drives meta + payload, predicts
// output beats and statistics from packet-level rules, compares per scenario.

module tb_udp_rx_port_demux_filter;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_listen_port = 16'd0;
  logic        cfg_filter_en = 1'b0;
  logic [31:0] m_pkt_src_ip;
  logic [15:0] m_pkt_src_port;
  logic [15:0] m_pkt_len;
  logic [31:0] stat_fwd_cnt, stat_drop_cnt, stat_len_err_cnt;

  udp_rx_meta_if   meta_if ();
  udp_rx_stream_if stream_if ();
  udp_rx_axis_if   axis_if ();

  udp_rx_port_demux_filter dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_listen_port_i  (cfg_listen_port),
    .cfg_filter_en_i    (cfg_filter_en),
    .s_udp_meta         (meta_if),
    .s_data_stream      (stream_if),
    .m_axis             (axis_if),
    .m_pkt_src_ip_o     (m_pkt_src_ip),
    .m_pkt_src_port_o   (m_pkt_src_port),
    .m_pkt_len_o        (m_pkt_len),
    .stat_fwd_cnt_o     (stat_fwd_cnt),
    .stat_drop_cnt_o    (stat_drop_cnt),
    .stat_len_err_cnt_o (stat_len_err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int rdy_idx = 0;
  int stall_viol = 0;
  int bp_viol = 0;
  int valid_cycles = 0;
  bit bp_chk_en = 1'b0;
  int exp_fwd = 0, exp_drop = 0, exp_err = 0;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [255:0] pkt_data [16];
  logic [31:0]  pkt_keep [16];
  logic         pkt_first[16];
  int           acc_cyc  [16];
  logic [15:0]  seen_src_port;
  logic [31:0]  seen_src_ip;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-side ready pattern, changed just after each rising edge.
  initial begin
    axis_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: axis_if.tready = 1'b1;
        1: begin
          axis_if.tready = (rdy_idx % 3) == 0;
          rdy_idx++;
        end
        default: axis_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output observer: collects taken beats and notes any change under stall.
  initial begin
    beat_t cur, prev;
    bit    prev_stalled;
    prev_stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {axis_if.tdata, axis_if.tkeep, axis_if.tlast, axis_if.tuser};
      if (!reset && prev_stalled && (!axis_if.tvalid || cur != prev)) stall_viol++;
      if (bp_chk_en && axis_if.tvalid && !axis_if.tready && stream_if.tready) bp_viol++;
      if (axis_if.tvalid) valid_cycles++;
      if (!reset && axis_if.tvalid && axis_if.tready) got_q.push_back(cur);
      prev_stalled = !reset && axis_if.tvalid && !axis_if.tready;
      prev = cur;
    end
  end

  // Drives one packet and predicts its effect from the packet-level rules.
  task automatic send_pkt(input logic [15:0] dst, input logic [15:0] src,
                          input logic [31:0] ip, input logic [15:0] len, input int nb);
    int  t;
    int  bytes;
    bit  ferr, err, fwd;
    bytes = 0;
    ferr = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bytes += $countones(pkt_keep[i]);
      if (i > 0 && pkt_first[i]) ferr = 1'b1;
    end
    err = ferr || (bytes != int'(len));
    fwd = !cfg_filter_en || (dst == cfg_listen_port);
    if (fwd) begin
      exp_fwd++;
      for (int i = 0; i < nb; i++)
        exp_q.push_back({pkt_data[i], pkt_keep[i], (i == nb - 1), (i == nb - 1) && err});
    end else begin
      exp_drop++;
    end
    if (err) exp_err++;

    @(posedge clk);
    #1;
    meta_if.valid    = 1'b1;
    meta_if.dst_port = dst;
    meta_if.src_port = src;
    meta_if.ip_addr  = ip;
    meta_if.data_len = len;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!meta_if.ready && t < 200);
    if (!meta_if.ready) begin
      total++;
      bad++;
      $display("FAIL meta_handshake_timeout ready=%0b required=1", meta_if.ready);
      meta_if.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    meta_if.valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      stream_if.tvalid = 1'b1;
      stream_if.tdata  = pkt_data[i];
      stream_if.tkeep  = pkt_keep[i];
      stream_if.tfirst = pkt_first[i];
      stream_if.tlast  = (i == nb - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!stream_if.tready && t < 500);
      if (!stream_if.tready) begin
        total++;
        bad++;
        $display("FAIL beat_handshake_timeout beat=%0d ready=0 required=1", i);
        stream_if.tvalid = 1'b0;
        return;
      end
      acc_cyc[i] = cyc;
      if (i == 0) begin
        seen_src_port = m_pkt_src_port;
        seen_src_ip   = m_pkt_src_ip;
      end
      @(posedge clk);
      #1;
    end
    stream_if.tvalid = 1'b0;
    stream_if.tlast  = 1'b0;
    stream_if.tfirst = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((got_q.size() < exp_q.size() || axis_if.tvalid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got_beats=%0d required=%0d", got_q.size(), exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_pkt(input int nb);
    for (int i = 0; i < nb; i++) begin
      pkt_data[i]  = {8{$urandom()}};
      pkt_keep[i]  = 32'hFFFF_FFFF;
      pkt_first[i] = (i == 0);
    end
  endtask

  task automatic test_reset();
    meta_if.valid = 1'b0;
    meta_if.dst_port = '0;
    meta_if.src_port = '0;
    meta_if.ip_addr = '0;
    meta_if.data_len = '0;
    stream_if.tvalid = 1'b0;
    stream_if.tdata = '0;
    stream_if.tkeep = '0;
    stream_if.tfirst = 1'b0;
    stream_if.tlast = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (meta_if.ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_meta_ready_during got=%0b required=0", meta_if.ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({meta_if.ready, stream_if.tready, axis_if.tvalid} !== 3'b100) begin
      bad++;
      $display("FAIL reset_readies got=%b required=100",
               {meta_if.ready, stream_if.tready, axis_if.tvalid});
    end
    total++;
    if ({stat_fwd_cnt, stat_drop_cnt, stat_len_err_cnt} !== 96'd0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d/%0d required=0/0/0",
               stat_fwd_cnt, stat_drop_cnt, stat_len_err_cnt);
    end
    total++;
    if ({m_pkt_src_ip, m_pkt_src_port, m_pkt_len, axis_if.tdata, axis_if.tkeep} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ip=%h port=%h len=%h keep=%h required=0",
               m_pkt_src_ip, m_pkt_src_port, m_pkt_len, axis_if.tkeep);
    end
  endtask

  task automatic test_forward_basic();
    cfg_filter_en = 1'b1;
    cfg_listen_port = 16'd4791;
    rdy_mode = 0;
    fill_pkt(2);
    pkt_keep[1] = 32'h0000_00FF;
    send_pkt(16'd4791, 16'd1234, 32'h0A00_0001, 16'd40, 2);
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL fwd_basic_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL fwd_basic_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stat_fwd_cnt !== 32'(exp_fwd) || m_pkt_len !== 16'd40) begin
      bad++;
      $display("FAIL fwd_basic_stats got fwd=%0d len=%0d required fwd=%0d len=40",
               stat_fwd_cnt, m_pkt_len, exp_fwd);
    end
    total++;
    if (seen_src_ip !== 32'h0A00_0001 || seen_src_port !== 16'd1234) begin
      bad++;
      $display("FAIL fwd_basic_sideband got ip=%h port=%0d required ip=0a000001 port=1234",
               seen_src_ip, seen_src_port);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_drop();
    int v0;
    fill_pkt(2);
    pkt_keep[1] = 32'h0000_00FF;
    v0 = valid_cycles;
    send_pkt(16'd5000, 16'd77, 32'h0A00_0002, 16'd40, 2);
    wait_drain();
    total++;
    if (valid_cycles != v0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL drop_no_output got valid_cycles=%0d beats=%0d required=0/0",
               valid_cycles - v0, got_q.size());
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] != 1) begin
      bad++;
      $display("FAIL drop_back_to_back got gap=%0d required=1", acc_cyc[1] - acc_cyc[0]);
    end
    total++;
    if (stat_drop_cnt !== 32'(exp_drop) || stat_fwd_cnt !== 32'(exp_fwd)) begin
      bad++;
      $display("FAIL drop_stats got drop=%0d fwd=%0d required drop=%0d fwd=%0d",
               stat_drop_cnt, stat_fwd_cnt, exp_drop, exp_fwd);
    end
    got_q.delete();
  endtask

  task automatic test_len_err();
    fill_pkt(2);
    send_pkt(16'd4791, 16'd9, 32'h0A00_0003, 16'd40, 2);
    fill_pkt(3);
    pkt_keep[2] = 32'h0000_000F;
    pkt_first[1] = 1'b1;
    send_pkt(16'd4791, 16'd10, 32'h0A00_0004, 16'd68, 3);
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL len_err_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL len_err_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stat_len_err_cnt !== 32'(exp_err) || stat_fwd_cnt !== 32'(exp_fwd)) begin
      bad++;
      $display("FAIL len_err_stats got err=%0d fwd=%0d required err=%0d fwd=%0d",
               stat_len_err_cnt, stat_fwd_cnt, exp_err, exp_fwd);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    rdy_idx = 0;
    rdy_mode = 1;
    stall_viol = 0;
    bp_viol = 0;
    bp_chk_en = 1'b1;
    fill_pkt(4);
    send_pkt(16'd4791, 16'd11, 32'h0A00_0005, 16'd128, 4);
    wait_drain();
    bp_chk_en = 1'b0;
    rdy_mode = 0;
    total++;
    if (stall_viol != 0 || bp_viol != 0) begin
      bad++;
      $display("FAIL bp_stall got stall_changes=%0d ready_while_full=%0d required=0/0",
               stall_viol, bp_viol);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    cfg_filter_en = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      fill_pkt(2);
      pkt_keep[1] = 32'h0000_FFFF;
      send_pkt(16'(p), 16'(100 + p), 32'(32'hC0A8_0000 + p), 16'd48, 2);
      total++;
      if (seen_src_port !== 16'(100 + p)) begin
        bad++;
        $display("FAIL b2b_src_port pkt=%0d got=%0d required=%0d", p, seen_src_port, 100 + p);
      end
    end
    wait_drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stat_fwd_cnt !== 32'(exp_fwd)) begin
      bad++;
      $display("FAIL b2b_fwd_cnt got=%0d required=%0d", stat_fwd_cnt, exp_fwd);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    logic [32:0] mask;
    int nb, bytes, tail;
    logic [15:0] dst, len;
    rdy_mode = 2;
    cfg_listen_port = 16'h1F00;
    for (int p = 0; p < 16; p++) begin
      cfg_filter_en = 1'($urandom_range(0, 3) != 0);
      nb = $urandom_range(1, 5);
      fill_pkt(nb);
      tail = $urandom_range(1, 32);
      mask = (33'd1 << tail) - 33'd1;
      pkt_keep[nb-1] = mask[31:0];
      bytes = 32 * (nb - 1) + tail;
      len = ($urandom_range(0, 3) == 0) ? 16'(bytes + $urandom_range(1, 9)) : 16'(bytes);
      if ($urandom_range(0, 5) == 0 && nb > 1) pkt_first[nb-1] = 1'b1;
      dst = ($urandom_range(0, 1) == 0) ? cfg_listen_port : 16'($urandom_range(0, 1000));
      send_pkt(dst, 16'($urandom()), $urandom(), len, nb);
    end
    wait_drain();
    rdy_mode = 0;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_beats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if ({stat_fwd_cnt, stat_drop_cnt, stat_len_err_cnt} !==
        {32'(exp_fwd), 32'(exp_drop), 32'(exp_err)}) begin
      bad++;
      $display("FAIL rand_stats got=%0d/%0d/%0d required=%0d/%0d/%0d", stat_fwd_cnt,
               stat_drop_cnt, stat_len_err_cnt, exp_fwd, exp_drop, exp_err);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    int t;
    cfg_filter_en = 1'b1;
    cfg_listen_port = 16'd4791;
    rdy_mode = 0;
    fill_pkt(4);
    @(posedge clk);
    #1;
    meta_if.valid = 1'b1;
    meta_if.dst_port = 16'd4791;
    meta_if.src_port = 16'd55;
    meta_if.data_len = 16'd128;
    @(negedge clk);
    @(posedge clk);
    #1;
    meta_if.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stream_if.tvalid = 1'b1;
      stream_if.tdata = pkt_data[i];
      stream_if.tkeep = pkt_keep[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!stream_if.tready && t < 100);
      @(posedge clk);
      #1;
    end
    total++;
    if (axis_if.tvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre_valid got=%0b required=1", axis_if.tvalid);
    end
    reset = 1'b1;
    stream_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({meta_if.ready, stream_if.tready, axis_if.tvalid} !== 3'b100) begin
      bad++;
      $display("FAIL reset_mid_readies got=%b required=100",
               {meta_if.ready, stream_if.tready, axis_if.tvalid});
    end
    total++;
    if ({stat_fwd_cnt, stat_drop_cnt, stat_len_err_cnt, m_pkt_len} !== '0) begin
      bad++;
      $display("FAIL reset_mid_counters got=%0d/%0d/%0d len=%0d required=0", stat_fwd_cnt,
               stat_drop_cnt, stat_len_err_cnt, m_pkt_len);
    end
    exp_q.delete();
    got_q.delete();
    exp_fwd = 0;
    exp_drop = 0;
    exp_err = 0;
  endtask

  initial begin
    test_reset();
    test_forward_basic();
    test_drop();
    test_len_err();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
